// File: rtl/wb_sram_slave_pkg.sv
// Shared Wishbone cycle/burst encodings, latched-request record and burst address stepping.
// Pure declarations; no latency or flow control of its own.
// Used by the slave and by the ICMU/DCMU masters that issue line fills.
package wb_sram_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_RECOVER
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Request fields captured at the start of a bus cycle.
    typedef struct packed {
        logic [29:0] addr;
        logic        we;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } wb_req_t;

    // Wrap modes step only the low bits; the rest of the word address is held.
    function automatic logic [29:0] next_addr(input logic [29:0] a, input logic [1:0] bte);
        logic [29:0] n;
        n = a;
        case (bte)
            BTE_WRAP4:  n[1:0] = a[1:0] + 2'd1;
            BTE_WRAP8:  n[2:0] = a[2:0] + 3'd1;
            BTE_WRAP16: n[3:0] = a[3:0] + 4'd1;
            default:    n      = a + 30'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sram_be.sv
// Single-port synchronous RAM, 32-bit words with four byte-write enables.
// Registered read: data for the address presented appears after the next clk edge.
// No flow control; a write cycle (any we bit set) leaves the read register unchanged.
module sram_be #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (|we) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B3 slave over sram_be: classic cycles plus CTI/BTE registered-feedback bursts.
// Latency: first beat 1+WAIT_CYCLES edges after the request, then one beat per cycle.
// Backpressure: stb low pauses a burst with address held; cyc low abandons the cycle.
module wb_sram_slave
    import wb_sram_slave_pkg::*;
#(
    parameter int          ADDR_BITS   = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:2] wbs_addr_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_data_i,
    output logic [31:0] wbs_data_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam int               TAG_W     = 30 - ADDR_BITS;
    localparam logic [TAG_W-1:0] BASE_TAG  = BASE_ADDR[31:ADDR_BITS+2];
    localparam logic [3:0]       WAIT_INIT = 4'(WAIT_CYCLES);

    state_t   state_q, state_d;
    wb_req_t  req_q, req_d;
    logic [3:0] cnt_q, cnt_d;

    logic        cyc_stb;
    logic        req_in_range;
    logic [29:0] addr_nxt;
    logic        beat_ack, beat_err;
    logic        rd_ahead;

    logic        ack_q, err_q;
    logic [31:0] data_q;

    logic [3:0]           ram_we;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [31:0]          ram_rdata;

    assign cyc_stb      = wbs_cyc_i & wbs_stb_i;
    assign req_in_range = (req_q.addr[29:ADDR_BITS] == BASE_TAG);
    assign addr_nxt     = next_addr(req_q.addr, req_q.bte);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        beat_ack = 1'b0;
        beat_err = 1'b0;
        rd_ahead = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cyc_stb) begin
                    req_d.addr = wbs_addr_i;
                    req_d.we   = wbs_we_i;
                    req_d.cti  = wbs_cti_i;
                    req_d.bte  = wbs_bte_i;
                    cnt_d      = WAIT_INIT;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (cyc_stb) begin
                    beat_ack = req_in_range;
                    beat_err = ~req_in_range;
                    if (req_in_range && req_q.cti == CTI_INCR) begin
                        req_d.addr = addr_nxt;
                        rd_ahead   = 1'b1;
                        state_d    = ST_BURST;
                    end else begin
                        state_d = ST_RECOVER;
                    end
                end
            end
            ST_BURST: begin
                if (cyc_stb) begin
                    beat_ack   = req_in_range;
                    beat_err   = ~req_in_range;
                    req_d.addr = addr_nxt;
                    rd_ahead   = 1'b1;
                    // Any cti other than incrementing closes the burst on this beat.
                    if (!req_in_range || wbs_cti_i != CTI_INCR) begin
                        state_d = ST_RECOVER;
                    end
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!wbs_cyc_i) begin
            state_d  = ST_IDLE;
            beat_ack = 1'b0;
            beat_err = 1'b0;
            rd_ahead = 1'b0;
        end
    end

    // Reads fetch the following word on an ack edge so the next beat's data is ready
    // one edge later; writes keep the port on the beat's own address.
    always_comb begin
        ram_addr = req_q.addr[ADDR_BITS-1:0];
        if (state_q == ST_IDLE) begin
            ram_addr = wbs_addr_i[ADDR_BITS+1:2];
        end else if (rd_ahead && !req_q.we) begin
            ram_addr = addr_nxt[ADDR_BITS-1:0];
        end
    end

    assign ram_we = (beat_ack && req_q.we) ? wbs_sel_i : 4'b0000;

    sram_be #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wbs_data_i),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            ack_q   <= beat_ack;
            err_q   <= beat_err;
            if (beat_ack && !req_q.we) begin
                data_q <= ram_rdata;
            end
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_err_o  = err_q;
    assign wbs_data_o = data_q;

endmodule
